// File: rtl/screen_state_ctrl.sv
// Frame-synchronous screen sequencer (START/PLAY/PAUSE/OVER) for the draw pipeline.
// Button requests are synchronized, edge-detected and latched until the next vblank boundary.
module screen_state_ctrl #(
    parameter int unsigned OVER_FRAMES = 180,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vblnk_in,
    input  logic             btn_start,
    input  logic             btn_pause,
    input  logic             game_over_in,
    output logic [1:0]       state,
    output logic             state_chg,
    output logic             frame_tick,
    output logic [CNT_W-1:0] over_cnt
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_FRAMES - 1);

    logic [1:0]       start_sync;
    logic [1:0]       pause_sync;
    logic             start_d;
    logic             pause_d;
    logic             start_p;
    logic             pause_p;
    logic             start_pend;
    logic             pause_pend;
    logic             start_req;
    logic             pause_req;
    logic             vblnk_d;
    logic             bnd;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_d;
    logic             chg_d;
    logic             tick_d;

    // Two-flop synchronizers plus one delay stage for rising-edge detection.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            start_sync <= 2'b00;
            pause_sync <= 2'b00;
            start_d    <= 1'b0;
            pause_d    <= 1'b0;
            vblnk_d    <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], btn_start};
            pause_sync <= {pause_sync[0], btn_pause};
            start_d    <= start_sync[1];
            pause_d    <= pause_sync[1];
            vblnk_d    <= vblnk_in;
        end
    end

    assign start_p = start_sync[1] & ~start_d;
    assign pause_p = pause_sync[1] & ~pause_d;
    assign bnd     = vblnk_in & ~vblnk_d;

    // Requests live for at most one frame; every boundary consumes or discards them.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            start_pend <= 1'b0;
            pause_pend <= 1'b0;
        end else if (bnd) begin
            start_pend <= 1'b0;
            pause_pend <= 1'b0;
        end else begin
            if (start_p) start_pend <= 1'b1;
            if (pause_p) pause_pend <= 1'b1;
        end
    end

    assign start_req = start_pend | start_p;
    assign pause_req = pause_pend | pause_p;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_START;
            over_cnt   <= '0;
            state_chg  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            over_cnt   <= cnt_d;
            state_chg  <= chg_d;
            frame_tick <= tick_d;
        end
    end

    // Next-state logic; nothing moves except on the vblank boundary cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = over_cnt;
        chg_d   = 1'b0;
        tick_d  = 1'b0;
        if (bnd) begin
            tick_d = 1'b1;
            case (state_q)
                ST_START: begin
                    if (start_req) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (game_over_in) begin
                        state_d = ST_OVER;
                        cnt_d   = '0;
                    end else if (pause_req) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (pause_req)      state_d = ST_PLAY;
                    else if (start_req) state_d = ST_START;
                end
                ST_OVER: begin
                    if (start_req || over_cnt == OVER_LAST) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = over_cnt + CNT_W'(1);
                    end
                end
                default: state_d = ST_START;
            endcase
            chg_d = (state_d != state_q);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Directed bench for screen_state_ctrl (OVER_FRAMES=4): each task drives one scenario and
// compares {state, state_chg, frame_tick, over_cnt} against hand-computed values.
module tb_screen_state_ctrl;

    logic       pclk;
    logic       rst;
    logic       vblnk_in;
    logic       btn_start;
    logic       btn_pause;
    logic       game_over_in;
    logic [1:0] state;
    logic       state_chg;
    logic       frame_tick;
    logic [7:0] over_cnt;

    int checks = 0;
    int errors = 0;

    screen_state_ctrl #(.OVER_FRAMES(4), .CNT_W(8)) dut (
        .pclk         (pclk),
        .rst          (rst),
        .vblnk_in     (vblnk_in),
        .btn_start    (btn_start),
        .btn_pause    (btn_pause),
        .game_over_in (game_over_in),
        .state        (state),
        .state_chg    (state_chg),
        .frame_tick   (frame_tick),
        .over_cnt     (over_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [11:0] obs();
        return {state, state_chg, frame_tick, over_cnt};
    endfunction

    function automatic logic [11:0] pk(input logic [1:0] s, input logic c, input logic t,
                                       input logic [7:0] n);
        return {s, c, t, n};
    endfunction

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic active(input int n);
        vblnk_in = 1'b0;
        step(n);
    endtask

    task automatic bnd_edge();
        vblnk_in = 1'b1;
        step(1);
    endtask

    task automatic frame_end();
        step(3);
        vblnk_in = 1'b0;
        step(1);
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        step(4);
        btn_start = 1'b0;
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        step(4);
        btn_pause = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; vblnk_in = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; game_over_in = 1'b0;
        step(3);
        checks++;
        if (obs() !== pk(2'd0, 1'b0, 1'b0, 8'd0)) begin
            errors++; $display("FAIL reset_init: got %h want %h", obs(), pk(2'd0, 1'b0, 1'b0, 8'd0));
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            active(20);
            bnd_edge();
            checks++;
            if (obs() !== pk(2'd0, 1'b0, 1'b1, 8'd0)) begin
                errors++; $display("FAIL idle_bnd%0d: got %h want %h", i, obs(), pk(2'd0, 1'b0, 1'b1, 8'd0));
            end
            step(1);
            checks++;
            if (obs() !== pk(2'd0, 1'b0, 1'b0, 8'd0)) begin
                errors++; $display("FAIL idle_after%0d: got %h want %h", i, obs(), pk(2'd0, 1'b0, 1'b0, 8'd0));
            end
            frame_end();
        end
    endtask

    task automatic test_start();
        btn_start = 1'b1;
        active(50);
        checks++;
        if (obs() !== pk(2'd0, 1'b0, 1'b0, 8'd0)) begin
            errors++; $display("FAIL start_hold: got %h want %h", obs(), pk(2'd0, 1'b0, 1'b0, 8'd0));
        end
        bnd_edge();
        checks++;
        if (obs() !== pk(2'd1, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL start_bnd: got %h want %h", obs(), pk(2'd1, 1'b1, 1'b1, 8'd0));
        end
        step(1);
        checks++;
        if (obs() !== pk(2'd1, 1'b0, 1'b0, 8'd0)) begin
            errors++; $display("FAIL start_after: got %h want %h", obs(), pk(2'd1, 1'b0, 1'b0, 8'd0));
        end
        frame_end();
        active(20);
        bnd_edge();
        checks++;
        if (obs() !== pk(2'd1, 1'b0, 1'b1, 8'd0)) begin
            errors++; $display("FAIL start_no_retrig: got %h want %h", obs(), pk(2'd1, 1'b0, 1'b1, 8'd0));
        end
        frame_end();
        btn_start = 1'b0;
        active(5);
    endtask

    task automatic test_pause();
        press_pause(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd2, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL pause_enter: got %h want %h", obs(), pk(2'd2, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        press_pause(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd1, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL pause_exit: got %h want %h", obs(), pk(2'd1, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        press_start(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd1, 1'b0, 1'b1, 8'd0)) begin
            errors++; $display("FAIL play_ignores_start: got %h want %h", obs(), pk(2'd1, 1'b0, 1'b1, 8'd0));
        end
        frame_end();
        press_pause(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd2, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL pause_again: got %h want %h", obs(), pk(2'd2, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        // A stale start or pause request would move PAUSE here.
        active(15); bnd_edge();
        checks++;
        if (obs() !== pk(2'd2, 1'b0, 1'b1, 8'd0)) begin
            errors++; $display("FAIL req_discarded: got %h want %h", obs(), pk(2'd2, 1'b0, 1'b1, 8'd0));
        end
        frame_end();
        game_over_in = 1'b1;
        active(15); bnd_edge();
        checks++;
        if (obs() !== pk(2'd2, 1'b0, 1'b1, 8'd0)) begin
            errors++; $display("FAIL pause_ignores_over: got %h want %h", obs(), pk(2'd2, 1'b0, 1'b1, 8'd0));
        end
        frame_end();
        game_over_in = 1'b0;
        press_pause(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd1, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL pause_resume: got %h want %h", obs(), pk(2'd1, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
    endtask

    task automatic test_reset_mid();
        active(10);
        checks++;
        if (obs() !== pk(2'd1, 1'b0, 1'b0, 8'd0)) begin
            errors++; $display("FAIL pre_reset_play: got %h want %h", obs(), pk(2'd1, 1'b0, 1'b0, 8'd0));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== pk(2'd0, 1'b0, 1'b0, 8'd0)) begin
            errors++; $display("FAIL reset_async: got %h want %h", obs(), pk(2'd0, 1'b0, 1'b0, 8'd0));
        end
        step(5);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            active(20); bnd_edge();
            checks++;
            if (obs() !== pk(2'd0, 1'b0, 1'b1, 8'd0)) begin
                errors++; $display("FAIL post_reset_bnd%0d: got %h want %h", i, obs(), pk(2'd0, 1'b0, 1'b1, 8'd0));
            end
            frame_end();
        end
    endtask

    task automatic test_boundary_req();
        active(10);
        btn_start = 1'b1;
        step(2);
        // start_p is high now; the next edge is also the boundary edge.
        vblnk_in = 1'b1;
        step(1);
        checks++;
        if (obs() !== pk(2'd1, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL bnd_cycle_req: got %h want %h", obs(), pk(2'd1, 1'b1, 1'b1, 8'd0));
        end
        btn_start = 1'b0;
        frame_end();
    endtask

    task automatic test_game_over();
        game_over_in = 1'b1;
        press_pause(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd3, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL over_beats_pause: got %h want %h", obs(), pk(2'd3, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        game_over_in = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            active(15); bnd_edge();
            checks++;
            if (obs() !== pk(2'd3, 1'b0, 1'b1, 8'(k))) begin
                errors++; $display("FAIL over_cnt%0d: got %h want %h", k, obs(), pk(2'd3, 1'b0, 1'b1, 8'(k)));
            end
            frame_end();
        end
        active(15); bnd_edge();
        checks++;
        if (obs() !== pk(2'd0, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL over_timeout: got %h want %h", obs(), pk(2'd0, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
    endtask

    task automatic test_simultaneous();
        press_start(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd1, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL sim_play: got %h want %h", obs(), pk(2'd1, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        press_pause(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd2, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL sim_pause: got %h want %h", obs(), pk(2'd2, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        btn_start = 1'b1; btn_pause = 1'b1;
        step(4);
        btn_start = 1'b0; btn_pause = 1'b0;
        active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd1, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL sim_pause_both: got %h want %h", obs(), pk(2'd1, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        game_over_in = 1'b1;
        active(15); bnd_edge();
        checks++;
        if (obs() !== pk(2'd3, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL sim_over: got %h want %h", obs(), pk(2'd3, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        game_over_in = 1'b0;
        active(15); bnd_edge();
        checks++;
        if (obs() !== pk(2'd3, 1'b0, 1'b1, 8'd1)) begin
            errors++; $display("FAIL sim_over_cnt1: got %h want %h", obs(), pk(2'd3, 1'b0, 1'b1, 8'd1));
        end
        frame_end();
        press_start(); active(10); bnd_edge();
        checks++;
        if (obs() !== pk(2'd0, 1'b1, 1'b1, 8'd0)) begin
            errors++; $display("FAIL sim_over_start_exit: got %h want %h", obs(), pk(2'd0, 1'b1, 1'b1, 8'd0));
        end
        frame_end();
        active(20); bnd_edge();
        checks++;
        if (obs() !== pk(2'd0, 1'b0, 1'b1, 8'd0)) begin
            errors++; $display("FAIL sim_idle: got %h want %h", obs(), pk(2'd0, 1'b0, 1'b1, 8'd0));
        end
        frame_end();
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_reset_mid();
        test_boundary_req();
        test_game_over();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
